lane_permute_alu: RTL and testbench

- Parametrised, pipelined lane-wise datapath unit: WIDTH-bit operand A passes through a runtime-programmable bit-permutation crossbar, then a lane-wise op combines it with operand B.
- Generalises fixed bit-shuffle, bitwise, enable-gate, mux and add/sub wiring into one configurable streaming block.
- Serves as the golden sequential target for vectorization-pass regression, with valid/ready on both sides.

---
 rtl/lane_permute_alu.sv | 130 +++++++++++++
 tb/tb_lane_permute_alu.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_permute_alu.sv
// Streaming lane-wise ALU: operand A is routed through a programmable bit crossbar,
// then combined with operand B in a two-stage valid/ready pipeline.
module lane_permute_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH),
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [IDXW-1:0]  cfg_src,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  txn_count
);

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_MUX  = 3'd6;
  localparam logic [2:0] OP_GATE = 3'd7;

  logic [IDXW-1:0]  map [WIDTH];
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_sel;

  logic             cfg_ok_c;
  logic             s2_free_c;
  logic             s1_adv_c;
  logic             accept_c;
  logic [WIDTH-1:0] a_p_c;
  logic [WIDTH-1:0] res_c;

  // Handshake chain: stage 2 frees when empty or drained, stage 1 follows it
  always_comb begin
    s2_free_c = !out_valid || out_ready;
    s1_adv_c  = s1_valid && s2_free_c;
    in_ready  = !s1_valid || s2_free_c;
    accept_c  = in_valid && in_ready;
    cfg_ok_c  = cfg_we && (32'(cfg_idx) < WIDTH) && (32'(cfg_src) < WIDTH);
  end

  // Crossbar reads the map before any same-edge write lands
  always_comb begin
    a_p_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      a_p_c[i] = in_a[map[i]];
    end
  end

  always_comb begin
    res_c = '0;
    case (s1_op)
      OP_PASS: res_c = s1_a;
      OP_AND:  res_c = s1_a & s1_b;
      OP_OR:   res_c = s1_a | s1_b;
      OP_XOR:  res_c = s1_a ^ s1_b;
      OP_ADD:  res_c = s1_a + s1_b;
      OP_SUB:  res_c = s1_a - s1_b;
      OP_MUX:  res_c = s1_sel ? s1_a : s1_b;
      OP_GATE: res_c = (s1_a ^ s1_b) & {WIDTH{s1_sel}};
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        map[i] <= IDXW'(i);
      end
    end else if (cfg_ok_c) begin
      map[cfg_idx] <= cfg_src;
    end
  end

  // Stage 1: permuted A plus the operands it will be combined with
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_PASS;
      s1_sel   <= 1'b0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_a     <= a_p_c;
      s1_b     <= in_b;
      s1_op    <= in_op;
      s1_sel   <= in_sel;
    end else if (s1_adv_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register holds while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s1_adv_c) begin
      out_valid <= 1'b1;
      out_data  <= res_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= '0;
    end else if (out_valid && out_ready) begin
      txn_count <= txn_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_lane_permute_alu.sv
// Scoreboard bench for lane_permute_alu: an 8-lane and a 4-lane instance, expected
// results queued at acceptance and compared by per-instance output monitors.
module tb_lane_permute_alu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cfg_we8, in_valid8, in_ready8, in_sel8, out_valid8, out_ready8;
  logic [2:0] cfg_idx8, cfg_src8, in_op8;
  logic [7:0] in_a8, in_b8, out_data8;
  logic [15:0] txn8;

  logic       cfg_we4, in_valid4, in_ready4, in_sel4, out_valid4, out_ready4;
  logic [1:0] cfg_idx4, cfg_src4;
  logic [2:0] in_op4;
  logic [3:0] in_a4, in_b4, out_data4;
  logic [15:0] txn4;

  lane_permute_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we8), .cfg_idx(cfg_idx8), .cfg_src(cfg_src8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8), .in_a(in_a8), .in_b(in_b8),
    .in_sel(in_sel8), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .txn_count(txn8));

  lane_permute_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we4), .cfg_idx(cfg_idx4), .cfg_src(cfg_src4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_op(in_op4), .in_a(in_a4), .in_b(in_b4),
    .in_sel(in_sel4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .txn_count(txn4));

  int tests = 0;
  int fails = 0;
  logic [7:0] q8[$];
  logic [3:0] q4[$];
  logic [7:0] e8;
  logic [3:0] e4;
  logic [2:0] m8 [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitors: a handshake happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (q8.size() == 0) check("out8_unexpected", 32'(out_data8), 32'hFFFF_FFFF);
      else begin
        e8 = q8.pop_front();
        check("out8_data", 32'(out_data8), 32'(e8));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (q4.size() == 0) check("out4_unexpected", 32'(out_data4), 32'hFFFF_FFFF);
      else begin
        e4 = q4.pop_front();
        check("out4_data", 32'(out_data4), 32'(e4));
      end
    end
  end

  function automatic logic [7:0] alu8(input logic [2:0] op, input logic [7:0] ap,
                                      input logic [7:0] b, input logic sel);
    case (op)
      3'd0: return ap;
      3'd1: return ap & b;
      3'd2: return ap | b;
      3'd3: return ap ^ b;
      3'd4: return ap + b;
      3'd5: return ap - b;
      3'd6: return sel ? ap : b;
      default: return (ap ^ b) & {8{sel}};
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic sel, input logic [7:0] exp);
    in_valid8 = 1'b1; in_op8 = op; in_a8 = a; in_b8 = b; in_sel8 = sel;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready8) begin
        q8.push_back(exp);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("send8_timeout", 32'd1, 32'd0);
    in_valid8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] exp);
    in_valid4 = 1'b1; in_op4 = 3'd0; in_a4 = a; in_b4 = 4'h0; in_sel4 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready4) begin
        q4.push_back(exp);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("send4_timeout", 32'd1, 32'd0);
    in_valid4 = 1'b0;
  endtask

  task automatic cfg4(input logic [1:0] idx, input logic [1:0] src);
    cfg_we4 = 1'b1; cfg_idx4 = idx; cfg_src4 = src;
    @(posedge clk); #1;
    cfg_we4 = 1'b0;
  endtask

  task automatic cfg8(input logic [2:0] idx, input logic [2:0] src);
    cfg_we8 = 1'b1; cfg_idx8 = idx; cfg_src8 = src;
    @(posedge clk); #1;
    cfg_we8 = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (q8.size() == 0 && q4.size() == 0 && !out_valid8 && !out_valid4) break;
      @(posedge clk); #1;
    end
    check(name, 32'(q8.size() + q4.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q8.delete(); q4.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int sent;
    logic [7:0] ap;
    rst = 1'b1;
    cfg_we8 = 0; cfg_idx8 = 0; cfg_src8 = 0; in_valid8 = 0; in_op8 = 0;
    in_a8 = 0; in_b8 = 0; in_sel8 = 0; out_ready8 = 1;
    cfg_we4 = 0; cfg_idx4 = 0; cfg_src4 = 0; in_valid4 = 0; in_op4 = 0;
    in_a4 = 0; in_b4 = 0; in_sel4 = 0; out_ready4 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_out_data", 32'(out_data8), 32'd0);
    check("rst_txn", 32'(txn8), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;

    // First transaction: latency and count
    send8(3'd3, 8'hA5, 8'h0F, 1'b0, 8'hAA);
    check("lat_accept_edge", 32'(out_valid8), 32'd0);
    @(posedge clk); #1;
    check("lat_second_edge", 32'(out_valid8), 32'd1);
    check("lat_data", 32'(out_data8), 32'hAA);
    @(posedge clk); #1;
    check("txn_after_first", 32'(txn8), 32'd1);

    // 4-lane permutation: reversal, fan-out, dropped lanes, same-edge write
    cfg4(2'd3, 2'd0); cfg4(2'd2, 2'd1); cfg4(2'd1, 2'd2); cfg4(2'd0, 2'd3);
    send4(4'h1, 4'h8);
    send4(4'h6, 4'h6);
    cfg4(2'd1, 2'd0); cfg4(2'd0, 2'd0);
    send4(4'h1, 4'hB);
    cfg_we4 = 1'b1; cfg_idx4 = 2'd3; cfg_src4 = 2'd2;
    send4(4'h4, 4'h0);
    cfg_we4 = 1'b0;
    send4(4'h4, 4'h8);
    drain("drain_perm4");
    check("txn4_count", 32'(txn4), 32'd5);

    // 8-lane ops with identity map
    send8(3'd4, 8'hFF, 8'h01, 1'b0, 8'h00);
    send8(3'd5, 8'h00, 8'h01, 1'b0, 8'hFF);
    send8(3'd6, 8'h3C, 8'hC3, 1'b1, 8'h3C);
    send8(3'd6, 8'h3C, 8'hC3, 1'b0, 8'hC3);
    send8(3'd7, 8'h3C, 8'hC3, 1'b0, 8'h00);
    send8(3'd7, 8'h3C, 8'hC0, 1'b1, 8'hFC);
    send8(3'd1, 8'hF0, 8'h3C, 1'b0, 8'h30);
    send8(3'd2, 8'hF0, 8'h3C, 1'b0, 8'hFC);
    send8(3'd0, 8'h5A, 8'hFF, 1'b1, 8'h5A);
    drain("drain_ops8");

    // Backpressure: two buffered, third blocked until the consumer drains
    do_reset();
    out_ready8 = 1'b0;
    in_valid8 = 1'b1; in_op8 = 3'd3; in_b8 = 8'h01; in_sel8 = 1'b0;
    in_a8 = 8'h11;
    @(negedge clk); check("bp_accept1", 32'(in_ready8), 32'd1); q8.push_back(8'h10);
    @(posedge clk); #1;
    in_a8 = 8'h22;
    @(negedge clk); check("bp_accept2", 32'(in_ready8), 32'd1); q8.push_back(8'h23);
    @(posedge clk); #1;
    in_a8 = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_block", 32'(in_ready8), 32'd0);
      check("bp_hold_valid", 32'(out_valid8), 32'd1);
      check("bp_hold_data", 32'(out_data8), 32'h10);
      @(posedge clk); #1;
    end
    out_ready8 = 1'b1;
    sent = 0;
    for (int i = 0; i < 10 && sent == 0; i++) begin
      @(negedge clk);
      if (in_ready8) begin q8.push_back(8'h32); sent = 1; end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    check("bp_third_accepted", 32'(sent), 32'd1);
    drain("drain_bp");
    check("bp_txn", 32'(txn8), 32'd3);

    // Asynchronous reset with traffic in flight and a non-identity map
    cfg8(3'd4, 3'd0);
    out_ready8 = 1'b0;
    send8(3'd0, 8'h01, 8'h00, 1'b0, 8'h11);
    send8(3'd0, 8'h02, 8'h00, 1'b0, 8'h02);
    @(negedge clk); #2;
    rst = 1'b1;
    q8.delete();
    #1;
    check("async_rst_valid", 32'(out_valid8), 32'd0);
    check("async_rst_txn", 32'(txn8), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready8 = 1'b1;
    send8(3'd0, 8'h12, 8'h00, 1'b0, 8'h12);
    drain("drain_identity");

    // Random stream against a transaction-level model
    do_reset();
    for (int i = 0; i < 8; i++) m8[i] = 3'(i);
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      in_valid8 = ($urandom_range(3) != 0);
      in_op8 = 3'($urandom_range(7));
      in_a8 = 8'($urandom_range(255));
      in_b8 = 8'($urandom_range(255));
      in_sel8 = 1'($urandom_range(1));
      out_ready8 = ($urandom_range(3) != 0);
      cfg_we8 = ($urandom_range(7) == 0);
      cfg_idx8 = 3'($urandom_range(7));
      cfg_src8 = 3'($urandom_range(7));
      @(negedge clk);
      if (in_valid8 && in_ready8) begin
        for (int k = 0; k < 8; k++) ap[k] = in_a8[m8[k]];
        q8.push_back(alu8(in_op8, ap, in_b8, in_sel8));
        sent++;
      end
      if (cfg_we8) m8[cfg_idx8] = cfg_src8;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0; cfg_we8 = 1'b0; out_ready8 = 1'b1;
    check("rand_sent", 32'(sent), 32'd1000);
    drain("drain_rand");
    check("rand_txn", 32'(txn8), 32'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
